// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the instruction decoder and alu_sequencer.
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_wr;
    logic [3:0] rsp_flags;
    logic [3:0] rsp_flag_mask;
    logic       rsp_illegal;

    modport master (
        output req_valid, req_op, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_wr, rsp_flags, rsp_flag_mask, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_wr, rsp_flags, rsp_flag_mask, rsp_illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences an external combinational 8-bit ALU through one or two passes to run
// the 6502 accumulator / read-modify-write ops (binary mode only).
module alu_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus,
    output logic           alu_add_en,
    output logic           alu_and_en,
    output logic           alu_xor_en,
    output logic           alu_or_en,
    output logic           alu_sr_en,
    output logic [7:0]     alu_a,
    output logic [7:0]     alu_b,
    output logic           alu_carry_in,
    input  logic [7:0]     alu_result,
    input  logic           alu_carry_out,
    input  logic           alu_ovflw
);
    localparam logic [3:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_AND = 4'd2,  OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4,  OP_CMP = 4'd5,  OP_ASL = 4'd6,  OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
    } req_t;

    state_t     state_q, state_d;
    req_t       req_q;
    logic [7:0] tmp_q;
    logic       c1_q;
    logic       accept, legal, fin_pass;

    logic       rsp_valid_q, rsp_wr_q, rsp_illegal_q;
    logic [7:0] rsp_result_q;
    logic [3:0] rsp_flags_q, rsp_mask_q;
    logic [3:0] flags_d, mask_d;
    logic       wr_d, res_n, res_z;

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_wr        = rsp_wr_q;
    assign bus.rsp_flags     = rsp_flags_q;
    assign bus.rsp_flag_mask = rsp_mask_q;
    assign bus.rsp_illegal   = rsp_illegal_q;

    assign accept   = bus.req_valid && bus.req_ready;
    assign legal    = (bus.req_op <= OP_BIT);
    assign fin_pass = (state_q == PASS1 && req_q.op != OP_ROR) || (state_q == PASS2);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = legal ? PASS1 : RESP;
            PASS1:   state_d = (req_q.op == OP_ROR) ? PASS2 : RESP;
            PASS2:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_add_en   = 1'b0;
        alu_and_en   = 1'b0;
        alu_xor_en   = 1'b0;
        alu_or_en    = 1'b0;
        alu_sr_en    = 1'b0;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_carry_in = 1'b0;
        if (state_q == PASS1) begin
            alu_a = req_q.a;
            unique case (req_q.op)
                OP_ADC:         begin alu_add_en = 1'b1; alu_b = req_q.b;  alu_carry_in = req_q.c; end
                OP_SBC:         begin alu_add_en = 1'b1; alu_b = ~req_q.b; alu_carry_in = req_q.c; end
                OP_CMP:         begin alu_add_en = 1'b1; alu_b = ~req_q.b; alu_carry_in = 1'b1;    end
                OP_AND, OP_BIT: begin alu_and_en = 1'b1; alu_b = req_q.b; end
                OP_ORA:         begin alu_or_en  = 1'b1; alu_b = req_q.b; end
                OP_EOR:         begin alu_xor_en = 1'b1; alu_b = req_q.b; end
                OP_ASL:         begin alu_add_en = 1'b1; alu_b = req_q.a; end
                OP_ROL:         begin alu_add_en = 1'b1; alu_b = req_q.a; alu_carry_in = req_q.c; end
                OP_LSR, OP_ROR: alu_sr_en = 1'b1;
                OP_INC:         begin alu_add_en = 1'b1; alu_carry_in = 1'b1; end
                OP_DEC:         begin alu_add_en = 1'b1; alu_b = 8'hFF; end
                default:        alu_a = 8'h00;
            endcase
        end else if (state_q == PASS2) begin
            // ROR second pass: merge the old carry into bit 7 of the shifted value
            alu_or_en = 1'b1;
            alu_a     = tmp_q;
            alu_b     = {req_q.c, 7'b0};
        end
    end

    assign res_n = alu_result[7];
    assign res_z = (alu_result == 8'h00);

    always_comb begin
        flags_d = 4'b0000;
        mask_d  = 4'b0000;
        wr_d    = 1'b0;
        unique case (req_q.op)
            OP_ADC, OP_SBC:         begin flags_d = {res_n, alu_ovflw, res_z, alu_carry_out}; mask_d = 4'b1111; wr_d = 1'b1; end
            OP_CMP:                 begin flags_d = {res_n, 1'b0, res_z, alu_carry_out};      mask_d = 4'b1011; end
            OP_AND, OP_ORA, OP_EOR: begin flags_d = {res_n, 1'b0, res_z, 1'b0};               mask_d = 4'b1010; wr_d = 1'b1; end
            OP_BIT:                 begin flags_d = {req_q.b[7], req_q.b[6], res_z, 1'b0};    mask_d = 4'b1110; end
            OP_ASL, OP_ROL, OP_LSR: begin flags_d = {res_n, 1'b0, res_z, alu_carry_out};      mask_d = 4'b1011; wr_d = 1'b1; end
            OP_ROR:                 begin flags_d = {res_n, 1'b0, res_z, c1_q};               mask_d = 4'b1011; wr_d = 1'b1; end
            OP_INC, OP_DEC:         begin flags_d = {res_n, 1'b0, res_z, 1'b0};               mask_d = 4'b1010; wr_d = 1'b1; end
            default:                wr_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= '0;
            tmp_q         <= 8'h00;
            c1_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 8'h00;
            rsp_flags_q   <= 4'b0000;
            rsp_mask_q    <= 4'b0000;
            rsp_wr_q      <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == RESP);
            if (accept)
                req_q <= '{op: bus.req_op, a: bus.req_a, b: bus.req_b, c: bus.req_c};
            if (state_q == PASS1 || state_q == PASS2) begin
                tmp_q <= alu_result;
                c1_q  <= alu_carry_out;
            end
            if (accept && !legal) begin
                rsp_result_q  <= bus.req_a;
                rsp_flags_q   <= 4'b0000;
                rsp_mask_q    <= 4'b0000;
                rsp_wr_q      <= 1'b0;
                rsp_illegal_q <= 1'b1;
            end else if (fin_pass) begin
                rsp_result_q  <= alu_result;
                rsp_flags_q   <= flags_d;
                rsp_mask_q    <= mask_d;
                rsp_wr_q      <= wr_d;
                rsp_illegal_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_add_en, alu_and_en, alu_xor_en, alu_or_en, alu_sr_en;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       alu_carry_in, alu_carry_out, alu_ovflw;

    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_add_en    (alu_add_en),
        .alu_and_en    (alu_and_en),
        .alu_xor_en    (alu_xor_en),
        .alu_or_en     (alu_or_en),
        .alu_sr_en     (alu_sr_en),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .alu_ovflw     (alu_ovflw)
    );

    // Behavioural model of the external combinational ALU
    always_comb begin
        logic [8:0] sum;
        sum           = 9'(alu_a) + 9'(alu_b) + 9'(alu_carry_in);
        alu_result    = 8'h00;
        alu_carry_out = 1'b0;
        alu_ovflw     = 1'b0;
        if (alu_add_en) begin
            alu_result    = sum[7:0];
            alu_carry_out = sum[8];
            alu_ovflw     = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
        end else if (alu_and_en) alu_result = alu_a & alu_b;
        else if (alu_xor_en) alu_result = alu_a ^ alu_b;
        else if (alu_or_en)  alu_result = alu_a | alu_b;
        else if (alu_sr_en) begin
            alu_result    = {1'b0, alu_a[7:1]};
            alu_carry_out = alu_a[0];
        end
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic       c;
        logic [7:0] res;
        logic [3:0] flags, mask;
        logic       wr, ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic c, logic [7:0] res,
                                logic [3:0] flags, logic [3:0] mask, logic wr, logic ill, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.res = res;
        v.flags = flags; v.mask = mask; v.wr = wr; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ens();
        return {alu_add_en, alu_and_en, alu_xor_en, alu_or_en, alu_sr_en};
    endfunction

    // Drive one request; returns #1 after the accepting edge
    task automatic do_req(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_c     = v.c;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        sb.push_back(v);
    endtask

    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!bus.rsp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
            return;
        end
        e = sb.pop_front();
        if (!bus.rsp_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_rsp_valid required=rsp_valid", tag);
            return;
        end
        chk({tag, "_result"}, 32'(bus.rsp_result), 32'(e.res));
        chk({tag, "_flags"},  32'(bus.rsp_flags), 32'(e.flags));
        chk({tag, "_mask"},   32'(bus.rsp_flag_mask), 32'(e.mask));
        chk({tag, "_wr"},     32'(bus.rsp_wr), 32'(e.wr));
        chk({tag, "_illegal"}, 32'(bus.rsp_illegal), 32'(e.ill));
        chk({tag, "_latency"}, lat, e.lat);
    endtask

    task automatic handshake(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_after_hs"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.req_c     = 1'b0;
        bus.rsp_ready = 1'b1;

        //          op     a      b      c     res    flags    mask     wr    ill   lat
        vecs.push_back(mk(4'd0,  8'h50, 8'h50, 1'b0, 8'hA0, 4'b1100, 4'b1111, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd1,  8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000, 4'b1111, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 4'b1010, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd3,  8'h00, 8'h00, 1'b1, 8'h00, 4'b0010, 4'b1010, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd4,  8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b1000, 4'b1010, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd5,  8'h40, 8'h40, 1'b0, 8'h00, 4'b0011, 4'b1011, 1'b0, 1'b0, 2));
        vecs.push_back(mk(4'd6,  8'h81, 8'h00, 1'b1, 8'h02, 4'b0001, 4'b1011, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd7,  8'h01, 8'h00, 1'b0, 8'h00, 4'b0011, 4'b1011, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd8,  8'h80, 8'h00, 1'b1, 8'h01, 4'b0001, 4'b1011, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd9,  8'h01, 8'h00, 1'b1, 8'h80, 4'b1001, 4'b1011, 1'b1, 1'b0, 3));
        vecs.push_back(mk(4'd10, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0010, 4'b1010, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd11, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b1000, 4'b1010, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd12, 8'h0F, 8'hC0, 1'b0, 8'h00, 4'b1110, 4'b1110, 1'b0, 1'b0, 2));
        vecs.push_back(mk(4'd14, 8'h5A, 8'h33, 1'b1, 8'h5A, 4'b0000, 4'b0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk(4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011, 4'b1111, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 4'b0101, 4'b1111, 1'b1, 1'b0, 2));
        vecs.push_back(mk(4'd9,  8'h02, 8'h00, 1'b0, 8'h01, 4'b0000, 4'b1011, 1'b1, 1'b0, 3));
        vecs.push_back(mk(4'd15, 8'hA5, 8'h00, 1'b0, 8'hA5, 4'b0000, 4'b0000, 1'b0, 1'b1, 1));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_fields", 32'({bus.rsp_result, bus.rsp_flags, bus.rsp_flag_mask, bus.rsp_wr, bus.rsp_illegal}), 0);
        chk("rst_alu_outs", 32'({ens(), alu_a, alu_b, alu_carry_in}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i]);
            wait_rsp(1, lat);
            check_rsp($sformatf("vec%0d", i), lat);
            handshake($sformatf("vec%0d", i));
        end

        // ADC: only the add enable, and only during the single pass
        do_req(vecs[0]);
        chk("adc_pass1_en", 32'(ens()), 32'b10000);
        chk("adc_pass1_ops", 32'({alu_a, alu_b, alu_carry_in}), 32'({8'h50, 8'h50, 1'b0}));
        wait_rsp(1, lat);
        chk("adc_resp_en", 32'(ens()), 0);
        check_rsp("adc_seq", lat);
        handshake("adc_seq");

        // ROR: shift pass then OR pass with the carry in bit 7
        do_req(vecs[9]);
        chk("ror_pass1_en", 32'(ens()), 32'b00001);
        chk("ror_pass1_a", 32'(alu_a), 'h01);
        @(posedge clk);
        #1;
        chk("ror_pass2_en", 32'(ens()), 32'b00010);
        chk("ror_pass2_ops", 32'({alu_a, alu_b}), 32'({8'h00, 8'h80}));
        wait_rsp(2, lat);
        check_rsp("ror_seq", lat);
        handshake("ror_seq");

        // Back-pressure: response held stable, new requests ignored
        bus.rsp_ready = 1'b0;
        do_req(vecs[15]);
        wait_rsp(1, lat);
        check_rsp("hold", lat);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd2;
        bus.req_a     = 8'h11;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_valid_ready", k), 32'({bus.rsp_valid, bus.req_ready}), 32'b10);
            chk($sformatf("hold%0d_rsp", k), 32'({bus.rsp_result, bus.rsp_flags, bus.rsp_flag_mask, bus.rsp_wr}),
                32'({8'h7F, 4'b0101, 4'b1111, 1'b1}));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        handshake("hold");
        @(posedge clk);
        #1;
        chk("hold_no_stray_req", 32'({bus.rsp_valid, bus.req_ready, ens()}), 32'b0100000);

        // Reset in PASS1 of ROR loses the operation
        do_req(vecs[9]);
        chk("rstmid_pass1_en", 32'(ens()), 32'b00001);
        rst_n = 1'b0;
        #2;
        chk("rstmid_state", 32'({bus.rsp_valid, bus.req_ready, ens()}), 32'b0100000);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_no_rsp", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);

        do_req(vecs[1]);
        wait_rsp(1, lat);
        check_rsp("post_rst", lat);
        handshake("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
